// File: rtl/silife_demo_seq.sv
// SiLife demo sequencer: writes a stored seed pattern into the cell
// grid row by row, then issues periodic generation-step pulses.
module silife_demo_seq #(
   parameter int ROWS = 32,
   parameter int COLS = 8,
   parameter int NUM_PATTERNS = 4,
   parameter logic [NUM_PATTERNS*ROWS*COLS-1:0] PATTERNS = '0,
   parameter int PERIOD_W = 32,
   parameter int RELOAD_GENS = 0,
   localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1,
   localparam int PSEL_W = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic [PSEL_W-1:0]   pattern_sel,
   input  logic                load_req,
   input  logic [PERIOD_W-1:0] period,
   input  logic                run,
   input  logic                single_step,
   output logic [ROW_W-1:0]    row_select,
   output logic [COLS-1:0]     cells,
   output logic                wr_en,
   output logic                step,
   output logic                busy,
   output logic [15:0]         gen_count
);

   typedef enum logic [1:0] {
      S_START,
      S_LOAD,
      S_RUN
   } state_e;

   state_e              state_q, state_d;
   logic [ROW_W-1:0]    row_q, row_d;
   logic                wr_en_q, wr_en_d;
   logic                step_q, step_d;
   logic [15:0]         gen_q, gen_d;
   logic [PERIOD_W-1:0] cnt_q, cnt_d;
   logic [PSEL_W-1:0]   pat_q, pat_d;
   logic [PSEL_W-1:0]   sel_ok;
   logic [PSEL_W-1:0]   pat_next;
   logic [COLS-1:0]     slice;
   logic                auto_reload;

   // Out-of-range selections fall back to pattern 0.
   always_comb begin
      sel_ok = pattern_sel;
      if (int'(pattern_sel) >= NUM_PATTERNS) begin
         sel_ok = '0;
      end
   end

   // Next pattern for auto-cycling, wrapping at NUM_PATTERNS.
   always_comb begin
      pat_next = pat_q + 1'b1;
      if (pat_q == PSEL_W'(NUM_PATTERNS - 1)) begin
         pat_next = '0;
      end
   end

   // Auto-reload fires once the configured generation count is reached.
   always_comb begin
      auto_reload = (RELOAD_GENS != 0) && (gen_q == 16'(RELOAD_GENS));
   end

   // Next-state logic; a disabled cycle only drops the strobes.
   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      wr_en_d = wr_en_q;
      step_d  = 1'b0;
      gen_d   = gen_q;
      cnt_d   = cnt_q;
      pat_d   = pat_q;
      if (!en) begin
         wr_en_d = 1'b0;
      end else begin
         unique case (state_q)
            S_START: begin
               pat_d   = sel_ok;
               row_d   = '0;
               state_d = S_LOAD;
            end
            S_LOAD: begin
               if (!wr_en_q) begin
                  wr_en_d = 1'b1;
               end else if (row_q == ROW_W'(ROWS - 1)) begin
                  wr_en_d = 1'b0;
                  cnt_d   = '0;
                  gen_d   = '0;
                  state_d = S_RUN;
               end else begin
                  row_d = row_q + 1'b1;
               end
            end
            S_RUN: begin
               if (load_req) begin
                  pat_d   = sel_ok;
                  row_d   = '0;
                  wr_en_d = 1'b0;
                  state_d = S_LOAD;
               end else if (auto_reload) begin
                  pat_d   = pat_next;
                  row_d   = '0;
                  wr_en_d = 1'b0;
                  state_d = S_LOAD;
               end else if (run) begin
                  if (cnt_q >= period) begin
                     step_d = 1'b1;
                     cnt_d  = '0;
                     gen_d  = gen_q + 1'b1;
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end else begin
                  step_d = single_step;
                  gen_d  = gen_q + 16'(single_step);
               end
            end
            default: begin
               state_d = S_START;
            end
         endcase
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_START;
         row_q   <= '0;
         wr_en_q <= 1'b0;
         step_q  <= 1'b0;
         gen_q   <= '0;
         cnt_q   <= '0;
         pat_q   <= '0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         wr_en_q <= wr_en_d;
         step_q  <= step_d;
         gen_q   <= gen_d;
         cnt_q   <= cnt_d;
         pat_q   <= pat_d;
      end
   end

   // Select the current row from the pattern table and mirror it.
   always_comb begin
      slice = COLS'(PATTERNS >> (((int'(pat_q) * ROWS)
              + (ROWS - 1 - int'(row_q))) * COLS));
      for (int i = 0; i < COLS; i++) begin
         cells[i] = slice[COLS-1-i];
      end
   end

   assign row_select = row_q;
   assign wr_en      = wr_en_q;
   assign step       = step_q;
   assign gen_count  = gen_q;
   assign busy       = (state_q == S_LOAD) || (state_q == S_START);

endmodule

// File: tb/tb_silife_demo_seq.sv
// Directed testbench for silife_demo_seq: load, pause, stepping,
// reload and auto-cycling, with hand-computed expected values.
module tb_silife_demo_seq;

   // Pattern p occupies bits [p*32 +: 32]; row 0 is the top byte.
   localparam logic [127:0] PAT_A = {
      8'hAA, 8'hBB, 8'hCC, 8'hDD,
      8'hC0, 8'h0A, 8'h70, 8'h05,
      8'h11, 8'h22, 8'h33, 8'h44,
      8'h01, 8'h80, 8'hF0, 8'h3C
   };
   localparam logic [95:0] PAT_B = {
      8'hFF, 8'h00, 8'hE0, 8'h07,
      8'h10, 8'h20, 8'h40, 8'h80,
      8'h01, 8'h02, 8'h04, 8'h08
   };

   // Bit-reversed rows 0..3 as seen on cells, row 0 in top byte.
   localparam logic [31:0] RA0 = 32'h80_01_0F_3C;
   localparam logic [31:0] RA1 = 32'h88_44_CC_22;
   localparam logic [31:0] RA2 = 32'h03_50_0E_A0;
   localparam logic [31:0] RA3 = 32'h55_DD_33_BB;
   localparam logic [31:0] RB0 = 32'h80_40_20_10;
   localparam logic [31:0] RB1 = 32'h08_04_02_01;
   localparam logic [31:0] RB2 = 32'hFF_00_07_E0;

   logic        clk;
   logic        rst_n, en, load_req, run, single_step;
   logic [1:0]  pattern_sel;
   logic [31:0] period;
   logic [1:0]  row_select;
   logic [7:0]  cells;
   logic        wr_en, step, busy;
   logic [15:0] gen_count;

   logic        rst2, en2, load_req2, run2, ss2;
   logic [1:0]  psel2;
   logic [31:0] period2;
   logic [1:0]  row2;
   logic [7:0]  cells2;
   logic        wr_en2, step2, busy2;
   logic [15:0] gen2;

   int checks = 0;
   int errors = 0;

   silife_demo_seq #(
      .ROWS(4), .COLS(8), .NUM_PATTERNS(4), .PATTERNS(PAT_A),
      .PERIOD_W(32), .RELOAD_GENS(0)
   ) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .pattern_sel(pattern_sel),
      .load_req(load_req), .period(period), .run(run),
      .single_step(single_step), .row_select(row_select),
      .cells(cells), .wr_en(wr_en), .step(step), .busy(busy),
      .gen_count(gen_count)
   );

   silife_demo_seq #(
      .ROWS(4), .COLS(8), .NUM_PATTERNS(3), .PATTERNS(PAT_B),
      .PERIOD_W(32), .RELOAD_GENS(2)
   ) dut2 (
      .clk(clk), .rst_n(rst2), .en(en2), .pattern_sel(psel2),
      .load_req(load_req2), .period(period2), .run(run2),
      .single_step(ss2), .row_select(row2),
      .cells(cells2), .wr_en(wr_en2), .step(step2), .busy(busy2),
      .gen_count(gen2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 0; en = 1; pattern_sel = 0; load_req = 0;
      run = 0; single_step = 0; period = 3;
      tick(); tick();
      checks++; if (row_select !== 2'd0) begin errors++;
         $display("FAIL reset_row: got %0d exp 0", row_select); end
      checks++; if (wr_en !== 1'b0) begin errors++;
         $display("FAIL reset_wr_en: got %b exp 0", wr_en); end
      checks++; if (step !== 1'b0) begin errors++;
         $display("FAIL reset_step: got %b exp 0", step); end
      checks++; if (gen_count !== 16'd0) begin errors++;
         $display("FAIL reset_gen: got %0d exp 0", gen_count); end
      checks++; if (busy !== 1'b1) begin errors++;
         $display("FAIL reset_busy: got %b exp 1", busy); end
   endtask

   task automatic test_load_from_reset();
      logic [31:0] e;
      e = RA0;
      rst_n = 1;
      tick();
      checks++; if (wr_en !== 1'b0 || busy !== 1'b1) begin errors++;
         $display("FAIL load_start: wr_en %b busy %b exp 0 1", wr_en, busy); end
      for (int r = 0; r < 4; r++) begin
         tick();
         checks++; if (wr_en !== 1'b1 || busy !== 1'b1) begin errors++;
            $display("FAIL load_wr r%0d: wr_en %b busy %b exp 1 1", r, wr_en, busy); end
         checks++; if (row_select !== 2'(r)) begin errors++;
            $display("FAIL load_row: got %0d exp %0d", row_select, r); end
         checks++; if (cells !== e[31-8*r -: 8]) begin errors++;
            $display("FAIL load_cells r%0d: got %h exp %h", r, cells, e[31-8*r -: 8]); end
      end
      tick();
      checks++; if (wr_en !== 1'b0 || busy !== 1'b0) begin errors++;
         $display("FAIL load_done: wr_en %b busy %b exp 0 0", wr_en, busy); end
      checks++; if (gen_count !== 16'd0 || step !== 1'b0) begin errors++;
         $display("FAIL load_done_gen: gen %0d step %b exp 0 0", gen_count, step); end
   endtask

   task automatic test_pause_mid_load();
      logic [31:0] e;
      logic [3:0]  seen;
      int          rows_exp [5];
      e = RA1;
      seen = '0;
      rows_exp = '{0, 1, 2, 2, 3};
      pattern_sel = 1; load_req = 1;
      tick();
      load_req = 0;
      checks++; if (busy !== 1'b1 || wr_en !== 1'b0) begin errors++;
         $display("FAIL pause_enter: busy %b wr_en %b exp 1 0", busy, wr_en); end
      for (int k = 0; k < 5; k++) begin
         if (k == 3) begin
            en = 0;
            for (int g = 0; g < 3; g++) begin
               tick();
               checks++; if (wr_en !== 1'b0 || row_select !== 2'd2 || busy !== 1'b1) begin
                  errors++;
                  $display("FAIL pause_hold: wr_en %b row %0d busy %b exp 0 2 1",
                           wr_en, row_select, busy);
               end
            end
            en = 1;
         end
         tick();
         checks++; if (wr_en !== 1'b1 || row_select !== 2'(rows_exp[k])) begin errors++;
            $display("FAIL pause_wr k%0d: wr_en %b row %0d exp 1 %0d",
                     k, wr_en, row_select, rows_exp[k]); end
         checks++; if (cells !== e[31-8*rows_exp[k] -: 8]) begin errors++;
            $display("FAIL pause_cells k%0d: got %h exp %h",
                     k, cells, e[31-8*rows_exp[k] -: 8]); end
         if (wr_en === 1'b1) seen[row_select] = 1'b1;
      end
      tick();
      checks++; if (wr_en !== 1'b0 || busy !== 1'b0) begin errors++;
         $display("FAIL pause_done: wr_en %b busy %b exp 0 0", wr_en, busy); end
      checks++; if (seen !== 4'hF) begin errors++;
         $display("FAIL pause_rows: got %b exp 1111", seen); end
   endtask

   task automatic test_periodic();
      period = 3; run = 1;
      for (int c = 1; c <= 14; c++) begin
         tick();
         checks++; if (step !== ((c % 4) == 0) || gen_count !== 16'((c > 12 ? 12 : c) / 4)) begin
            errors++;
            $display("FAIL periodic c%0d: step %b gen %0d exp %b %0d",
                     c, step, gen_count, (c % 4) == 0, (c > 12 ? 12 : c) / 4);
         end
      end
      period = 0;
      for (int k = 1; k <= 4; k++) begin
         tick();
         checks++; if (step !== 1'b1 || gen_count !== 16'(3 + k)) begin errors++;
            $display("FAIL period0 k%0d: step %b gen %0d exp 1 %0d",
                     k, step, gen_count, 3 + k); end
      end
   endtask

   task automatic test_single_step();
      int stray;
      stray = 0;
      period = 3;
      tick(); tick();
      checks++; if (step !== 1'b0 || gen_count !== 16'd7) begin errors++;
         $display("FAIL ss_pre: step %b gen %0d exp 0 7", step, gen_count); end
      run = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (step !== 1'b0) stray++;
      end
      single_step = 1;
      tick();
      single_step = 0;
      checks++; if (step !== 1'b1 || gen_count !== 16'd8) begin errors++;
         $display("FAIL ss_pulse: step %b gen %0d exp 1 8", step, gen_count); end
      for (int i = 0; i < 20; i++) begin
         tick();
         if (step !== 1'b0 || gen_count !== 16'd8) stray++;
      end
      checks++; if (stray != 0) begin errors++;
         $display("FAIL ss_quiet: got %0d stray cycles exp 0", stray); end
      run = 1;
      tick();
      checks++; if (step !== 1'b0) begin errors++;
         $display("FAIL ss_resume1: step %b exp 0", step); end
      tick();
      checks++; if (step !== 1'b1 || gen_count !== 16'd9) begin errors++;
         $display("FAIL ss_resume2: step %b gen %0d exp 1 9", step, gen_count); end
      run = 0;
   endtask

   task automatic test_reload();
      logic [31:0] e;
      e = RA3;
      pattern_sel = 3; load_req = 1;
      tick();
      load_req = 0;
      for (int r = 0; r < 4; r++) begin
         tick();
         checks++; if (wr_en !== 1'b1 || cells !== e[31-8*r -: 8]) begin errors++;
            $display("FAIL reload3 r%0d: wr_en %b cells %h exp 1 %h",
                     r, wr_en, cells, e[31-8*r -: 8]); end
      end
      tick();
      single_step = 1;
      for (int k = 1; k <= 5; k++) begin
         tick();
         checks++; if (step !== 1'b1 || gen_count !== 16'(k)) begin errors++;
            $display("FAIL held_ss k%0d: step %b gen %0d exp 1 %0d",
                     k, step, gen_count, k); end
      end
      single_step = 0;
      tick();
      e = RA2;
      pattern_sel = 2; load_req = 1;
      tick();
      checks++; if (busy !== 1'b1 || wr_en !== 1'b0 || step !== 1'b0 || gen_count !== 16'd5) begin
         errors++;
         $display("FAIL reload_enter: busy %b wr_en %b step %b gen %0d exp 1 0 0 5",
                  busy, wr_en, step, gen_count);
      end
      pattern_sel = 3;
      for (int r = 0; r < 4; r++) begin
         tick();
         checks++; if (wr_en !== 1'b1 || row_select !== 2'(r)) begin errors++;
            $display("FAIL reload_wr r%0d: wr_en %b row %0d exp 1 %0d",
                     r, wr_en, row_select, r); end
         checks++; if (cells !== e[31-8*r -: 8]) begin errors++;
            $display("FAIL reload_cells r%0d: got %h exp %h", r, cells, e[31-8*r -: 8]); end
      end
      load_req = 0;
      tick();
      checks++; if (busy !== 1'b0 || gen_count !== 16'd0) begin errors++;
         $display("FAIL reload_done: busy %b gen %0d exp 0 0", busy, gen_count); end
   endtask

   task automatic test_en_freeze();
      period = 0; run = 1;
      tick();
      checks++; if (step !== 1'b1 || gen_count !== 16'd1) begin errors++;
         $display("FAIL freeze_pre: step %b gen %0d exp 1 1", step, gen_count); end
      en = 0;
      tick(); tick();
      checks++; if (step !== 1'b0 || gen_count !== 16'd1) begin errors++;
         $display("FAIL freeze_hold: step %b gen %0d exp 0 1", step, gen_count); end
      en = 1;
      tick();
      checks++; if (step !== 1'b1 || gen_count !== 16'd2) begin errors++;
         $display("FAIL freeze_resume: step %b gen %0d exp 1 2", step, gen_count); end
      run = 0;
   endtask

   task automatic test_reset_abort();
      logic [31:0] e;
      e = RA0;
      pattern_sel = 1; load_req = 1;
      tick();
      load_req = 0;
      tick(); tick();
      rst_n = 0;
      tick();
      checks++; if (row_select !== 2'd0 || wr_en !== 1'b0 || busy !== 1'b1 || gen_count !== 16'd0) begin
         errors++;
         $display("FAIL abort_reset: row %0d wr_en %b busy %b gen %0d exp 0 0 1 0",
                  row_select, wr_en, busy, gen_count);
      end
      rst_n = 1; pattern_sel = 0;
      tick(); tick();
      checks++; if (wr_en !== 1'b1 || row_select !== 2'd0 || cells !== e[31:24]) begin
         errors++;
         $display("FAIL abort_restart: wr_en %b row %0d cells %h exp 1 0 %h",
                  wr_en, row_select, cells, e[31:24]);
      end
      for (int i = 0; i < 4; i++) tick();
   endtask

   task automatic test_auto_reload();
      logic [31:0] seq [4];
      logic [31:0] e;
      int n;
      seq = '{RB0, RB1, RB2, RB0};
      rst2 = 1;
      for (int p = 0; p < 4; p++) begin
         e = seq[p];
         n = 0;
         do begin
            tick();
            n++;
         end while (wr_en2 !== 1'b1 && n < 10);
         checks++; if (wr_en2 !== 1'b1) begin errors++;
            $display("FAIL auto_wait p%0d: wr_en %b exp 1 within 10 cycles", p, wr_en2); end
         for (int r = 0; r < 4; r++) begin
            if (r > 0) tick();
            checks++; if (row2 !== 2'(r) || cells2 !== e[31-8*r -: 8]) begin errors++;
               $display("FAIL auto_rows p%0d r%0d: row %0d cells %h exp %0d %h",
                        p, r, row2, cells2, r, e[31-8*r -: 8]); end
         end
         tick();
         checks++; if (busy2 !== 1'b0 || gen2 !== 16'd0) begin errors++;
            $display("FAIL auto_done p%0d: busy %b gen %0d exp 0 0", p, busy2, gen2); end
         for (int k = 1; k <= 2; k++) begin
            tick();
            checks++; if (step2 !== 1'b1 || gen2 !== 16'(k)) begin errors++;
               $display("FAIL auto_step p%0d k%0d: step %b gen %0d exp 1 %0d",
                        p, k, step2, gen2, k); end
         end
         tick();
         checks++; if (busy2 !== 1'b1 || step2 !== 1'b0) begin errors++;
            $display("FAIL auto_trigger p%0d: busy %b step %b exp 1 0", p, busy2, step2); end
      end
   endtask

   initial begin
      rst2 = 0; en2 = 1; psel2 = 3; load_req2 = 0;
      run2 = 1; ss2 = 0; period2 = 0;
      test_reset();
      test_load_from_reset();
      test_pause_mid_load();
      test_periodic();
      test_single_step();
      test_reload();
      test_en_freeze();
      test_reset_abort();
      test_auto_reload();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

endmodule
